// File: rtl/rv_defs.sv
// Shared RV32I definitions: opcode constants, the canonical NOP and the fetch
// state encoding used by the fetch stage.
package rv_defs;

  // Major opcodes (bits [6:0]); decode and immediate extension use these too.
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // addi x0,x0,0 -- the IR value whenever nothing valid is held.
  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

  // Fetch state machine encoding.
  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_HOLD  = 2'd1,
    FS_DRAIN = 2'd2,
    FS_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, reads instruction words over a req/ack
// handshake (one outstanding request, no overlap) and holds the result in the
// IR for decode. Redirects from execute replace the PC; a misaligned redirect
// halts fetch until reset.
module instr_fetch
  import rv_defs::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         valid_q, valid_d;
  logic         fault_q, fault_d;

  logic redir_ok;
  logic redir_bad;

  assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Request side decodes from state; a request pending in DRAIN keeps its address.
  always_comb begin
    mem_req  = !rst && ((state_q == FS_FETCH) || (state_q == FS_DRAIN));
    mem_addr = req_addr_q;
  end

  assign instr_valid = valid_q;
  assign instr       = ir_q;
  assign instr_pc    = instr_pc_q;
  assign fault       = fault_q;

  // Next-state and datapath update; every target holds its value by default.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    ir_d       = ir_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;

    if (state_q != FS_HALT && redir_bad) begin
      // Misaligned target: flush and stop; any pending ack is simply ignored.
      fault_d = 1'b1;
      valid_d = 1'b0;
      ir_d    = NOP_INSTR;
      state_d = FS_HALT;
    end else begin
      unique case (state_q)
        FS_FETCH: begin
          if (redir_ok) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            ir_d    = NOP_INSTR;
            if (mem_ack) begin
              // Response to the stale address is dropped; refetch from the target.
              req_addr_d = redirect_pc;
            end else begin
              state_d = FS_DRAIN;
            end
          end else if (mem_ack) begin
            ir_d       = mem_rdata;
            instr_pc_d = req_addr_q;
            pc_d       = req_addr_q + 32'd4;
            valid_d    = 1'b1;
            state_d    = FS_HOLD;
          end
        end
        FS_HOLD: begin
          if (redir_ok) begin
            // Flush wins over stall.
            pc_d       = redirect_pc;
            req_addr_d = redirect_pc;
            valid_d    = 1'b0;
            ir_d       = NOP_INSTR;
            state_d    = FS_FETCH;
          end else if (!stall) begin
            valid_d    = 1'b0;
            ir_d       = NOP_INSTR;
            req_addr_d = pc_q;
            state_d    = FS_FETCH;
          end
        end
        FS_DRAIN: begin
          // Newest redirect target wins; the old request must still complete.
          if (redir_ok) begin
            pc_d = redirect_pc;
          end
          if (mem_ack) begin
            // An ack that coincides with a redirect retires the old request,
            // so fetch resumes directly at the newest target.
            req_addr_d = redir_ok ? redirect_pc : pc_q;
            state_d    = FS_FETCH;
          end
        end
        FS_HALT: begin
          valid_d = 1'b0;
        end
        default: begin
          state_d = FS_HALT;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      ir_q       <= NOP_INSTR;
      instr_pc_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ir_q       <= ir_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch. Each row gives the inputs for
// one cycle and the outputs expected in that same cycle (before the edge).
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic        mem_req, instr_valid, fault;
  logic [31:0] mem_addr, instr, instr_pc;
  logic        mem_req2, instr_valid2, fault2;
  logic [31:0] mem_addr2, instr2, instr_pc2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .fault(fault)
  );

  // Second instance exercises PC wrap from the top of the address space.
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2), .fault(fault2)
  );

  typedef struct {
    logic        st;
    logic        ack;
    logic [31:0] rd;
    logic        rv;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins;
    logic [31:0] ipc;
    logic        flt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic ack, input logic [31:0] rd,
                     input logic rv, input logic [31:0] rpc,
                     input logic req, input logic [31:0] addr, input logic vld,
                     input logic [31:0] ins, input logic [31:0] ipc, input logic flt);
    vec_t v;
    v.st = st; v.ack = ack; v.rd = rd; v.rv = rv; v.rpc = rpc;
    v.req = req; v.addr = addr; v.vld = vld; v.ins = ins; v.ipc = ipc; v.flt = flt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_ack = 1'b0; mem_rdata = 32'h0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
  endtask

  initial begin
    // Columns: stall ack rdata redir redir_pc | req addr valid instr instr_pc fault
    // 1: back-to-back fetches with same-cycle ack
    add(0,1,32'hA000_0001,0,0, 1,32'h000,0,NOP,32'h000,0);
    add(0,0,0,0,0,             0,32'h000,1,32'hA000_0001,32'h000,0);
    add(0,1,32'hA000_0002,0,0, 1,32'h004,0,NOP,32'h000,0);
    add(0,0,0,0,0,             0,32'h004,1,32'hA000_0002,32'h004,0);
    // 2: ack delayed three cycles, request held steady
    add(0,0,32'hDEAD_0000,0,0, 1,32'h008,0,NOP,32'h004,0);
    add(0,0,0,0,0,             1,32'h008,0,NOP,32'h004,0);
    add(0,0,0,0,0,             1,32'h008,0,NOP,32'h004,0);
    add(0,1,32'hA000_0003,0,0, 1,32'h008,0,NOP,32'h004,0);
    // 3: five stalled cycles in HOLD, then resume at pc+4
    for (int k = 0; k < 5; k++)
      add(1,0,0,0,0,           0,32'h008,1,32'hA000_0003,32'h008,0);
    add(0,0,0,0,0,             0,32'h008,1,32'hA000_0003,32'h008,0);
    add(0,1,32'hA000_0004,0,0, 1,32'h00C,0,NOP,32'h008,0);
    add(0,0,0,0,0,             0,32'h00C,1,32'hA000_0004,32'h00C,0);
    // 4: redirect to 0x100 while request to 0x10 pending; drain then refetch
    add(0,0,0,1,32'h100,       1,32'h010,0,NOP,32'h00C,0);
    add(0,0,0,0,0,             1,32'h010,0,NOP,32'h00C,0);
    add(0,1,32'hBAD0_0010,0,0, 1,32'h010,0,NOP,32'h00C,0);
    add(0,1,32'hA000_0100,0,0, 1,32'h100,0,NOP,32'h00C,0);
    add(0,0,0,0,0,             0,32'h100,1,32'hA000_0100,32'h100,0);
    // 5a: redirect to 0x200 in the same cycle as the ack
    add(0,1,32'hBAD0_0104,1,32'h200, 1,32'h104,0,NOP,32'h100,0);
    add(0,1,32'hA000_0200,0,0, 1,32'h200,0,NOP,32'h100,0);
    // 5b: redirect while stalled in HOLD flushes the IR
    add(1,0,0,1,32'h300,       0,32'h200,1,32'hA000_0200,32'h200,0);
    add(1,0,0,0,0,             1,32'h300,0,NOP,32'h200,0);
    add(0,1,32'hA000_0300,0,0, 1,32'h300,0,NOP,32'h200,0);
    add(0,0,0,0,0,             0,32'h300,1,32'hA000_0300,32'h300,0);
    // 6: misaligned redirect halts; later redirects and acks are ignored
    add(0,0,0,1,32'h102,       1,32'h304,0,NOP,32'h300,0);
    add(0,1,32'hBAD0_0400,1,32'h400, 0,32'h304,0,NOP,32'h300,1);
    add(0,0,0,0,0,             0,32'h304,0,NOP,32'h300,1);
    add(0,0,0,0,0,             0,32'h304,0,NOP,32'h300,1);

    // Reset: first edge with rst high, still in reset -> no request
    idle_inputs();
    rst = 1'b1;
    tick();
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_ipc", instr_pc, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_req_wrap", {31'b0, mem_req2}, 32'd0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].st; mem_ack = vecs[i].ack; mem_rdata = vecs[i].rd;
      redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("v%0d_req", i),   {31'b0, mem_req},     {31'b0, vecs[i].req});
      chk($sformatf("v%0d_addr", i),  mem_addr,             vecs[i].addr);
      chk($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].vld});
      chk($sformatf("v%0d_instr", i), instr,                vecs[i].ins);
      chk($sformatf("v%0d_ipc", i),   instr_pc,             vecs[i].ipc);
      chk($sformatf("v%0d_fault", i), {31'b0, fault},       {31'b0, vecs[i].flt});
      // The wrap instance sees the same handshake during the first rows.
      if (i == 0) chk("wrap_addr0", mem_addr2, 32'hFFFF_FFFC);
      if (i == 1) chk("wrap_ipc0", instr_pc2, 32'hFFFF_FFFC);
      if (i == 2) chk("wrap_addr1", mem_addr2, 32'h0000_0000);
      if (i == 3) chk("wrap_ipc1", instr_pc2, 32'h0000_0000);
      tick();
    end

    // Reset out of HALT clears the fault and restarts at RESET_PC.
    idle_inputs();
    rst = 1'b1;
    tick();
    chk("halt_rst_req", {31'b0, mem_req}, 32'd0);
    chk("halt_rst_fault", {31'b0, fault}, 32'd0);
    rst = 1'b0;
    #1;
    chk("after_rst_req", {31'b0, mem_req}, 32'd1);
    chk("after_rst_addr", mem_addr, 32'h0);

    // Misaligned redirect while draining goes to HALT despite a later ack.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0041;
    tick();
    idle_inputs();
    mem_ack = 1'b1;
    #1;
    chk("drain_bad_fault", {31'b0, fault}, 32'd1);
    chk("drain_bad_req", {31'b0, mem_req}, 32'd0);
    tick();
    chk("drain_bad_valid", {31'b0, instr_valid}, 32'd0);
    chk("drain_bad_instr", instr, NOP);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Absolute time bound so the bench cannot run forever.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
